// File: rtl/mcycle_mul.sv
// Iterative shift-add 32x32 -> 64-bit multiplier, signed or unsigned per request.
// One add/shift step per clock; Busy stalls the pipeline until the product is written.
module mcycle_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SIGN    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               neg;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic               last_iter;

    // Magnitudes: the most negative value maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        op1_abs   = (MCycleOp && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
        op2_abs   = (MCycleOp && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
        sum       = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        product   = {hi, lo};
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        case (state)
            IDLE: begin
                Busy = Start;
                if (Start) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                Busy = 1'b1;
                if (last_iter) begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                Busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: the add carry-out lands in hi's MSB through the right shift.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt     <= '0;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            neg     <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand <= op1_abs;
                        hi    <= '0;
                        lo    <= op2_abs;
                        neg   <= MCycleOp & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                        cnt   <= '0;
                    end
                end
                COMPUTE: begin
                    hi  <= sum[WIDTH:1];
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                SIGN: begin
                    {Result2, Result1} <= neg ? -product : product;
                    Done               <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
